program_memory_arbiter: RTL and testbench

Shares one read port of the program memory (fixed-latency instruction read port: address + read_request in, instr + data_valid out N cycles later) between several requesters, e.g. CPU fetch, CPU data load and the debug/display reader. Grants at most one read per cycle, tracks the owner of every in-flight read in a tag pipeline matched to the memory latency, and routes each returning word to its owner. Sits between the requesters and a program_memory_bus consumer port (CONSUMER_A or CONSUMER_B).

---
 rtl/program_memory_arbiter_if.sv | 28 ++
 rtl/program_memory_arbiter.sv | 83 ++++++++
 tb/tb_program_memory_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_memory_arbiter_if.sv
// Requester and program-memory read-port signals of program_memory_arbiter.
// slave = arbiter side, master = requesters plus memory bus side.
interface program_memory_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [31:0]                   resp_instr;
  logic [NUM_REQ-1:0]            resp_valid;
  logic                          mem_ready;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_read_request;
  logic [31:0]                   mem_instr;
  logic                          mem_data_valid;
  logic                          err_out;

  modport slave (
    input  req_valid, req_addr, mem_ready, mem_instr, mem_data_valid,
    output req_ready, resp_instr, resp_valid, mem_addr, mem_read_request, err_out
  );

  modport master (
    output req_valid, req_addr, mem_ready, mem_instr, mem_data_valid,
    input  req_ready, resp_instr, resp_valid, mem_addr, mem_read_request, err_out
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// Shares one fixed-latency program-memory read port among NUM_REQ requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index).
module program_memory_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  program_memory_arbiter_if.slave  bus
);

  localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned N_REQ = NUM_REQ;
  localparam int          TAG_W = READ_LATENCY * IDX_W;

  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_found;
  logic                    grant;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [TAG_W-1:0]        tag_idx;
  logic                    tail_valid;
  logic [IDX_W-1:0]        tail_idx;
  logic                    err_q;

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int unsigned'(last_grant) + k) % N_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`else
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'(k);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  assign grant                = bus.mem_ready && grant_found;
  assign bus.req_ready        = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.mem_read_request = grant;
  assign bus.mem_addr         = grant ? bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;

  // Stage 0 sits in the low bits; the oldest read (tail) is the top stage.
  assign tail_valid = tag_valid[READ_LATENCY-1];
  assign tail_idx   = tag_idx[(READ_LATENCY-1)*IDX_W +: IDX_W];

  assign bus.resp_instr = bus.mem_instr;
  assign bus.resp_valid = (bus.mem_data_valid && tail_valid) ? (NUM_REQ'(1) << tail_idx) : '0;
  assign bus.err_out    = err_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      tag_valid  <= '0;
      tag_idx    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant) last_grant <= grant_idx;
      tag_valid <= READ_LATENCY'({tag_valid, grant});
      tag_idx   <= TAG_W'({tag_idx, grant_idx});
      if (bus.mem_data_valid != tail_valid) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Scoreboard bench for program_memory_arbiter with a 2-stage memory read model.
module tb_program_memory_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int READ_LATENCY = 2;
  localparam int ADDR_WIDTH   = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  program_memory_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  program_memory_arbiter #(
    .NUM_REQ(NUM_REQ),
    .READ_LATENCY(READ_LATENCY),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_last;

  typedef struct {
    int          due;
    logic [1:0]  owner;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: fixed 2-cycle read pipe sharing rst_in with the arbiter.
  logic        mv0, mv1, inject;
  logic [31:0] ma0, ma1;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mv0 <= 1'b0; mv1 <= 1'b0; ma0 <= '0; ma1 <= '0;
    end else begin
      mv0 <= bus.mem_read_request; ma0 <= bus.mem_addr;
      mv1 <= mv0;                  ma1 <= ma0;
    end
  end
  assign bus.mem_data_valid = mv1 | inject;
  assign bus.mem_instr      = mv1 ? mem_word(ma1) : 32'hDEAD_BEEF;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        if (bus.resp_valid !== sb[0].owner || bus.resp_instr !== sb[0].instr) begin
          errors++;
          $display("FAIL resp cyc %0d: got valid=%b instr=%h, want valid=%b instr=%h",
                   cyc, bus.resp_valid, bus.resp_instr, sb[0].owner, sb[0].instr);
        end
        void'(sb.pop_front());
      end else if (bus.resp_valid !== 2'b00) begin
        errors++;
        $display("FAIL resp_idle cyc %0d: got valid=%b, want 00", cyc, bus.resp_valid);
      end
    end
  end

  function automatic int pick(input logic [1:0] v, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
`else
    for (int c = 0; c < NUM_REQ; c++) if (v[c]) return c;
`endif
    return -1;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic mr);
    @(posedge clk_in); #1;
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.mem_ready = mr;
    @(negedge clk_in);
  endtask

  task automatic predict(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                         input logic mr, output logic [1:0] er, output logic [31:0] ea);
    int   g;
    exp_t e;
    g  = mr ? pick(v, exp_last) : -1;
    er = '0;
    ea = '0;
    if (g >= 0) begin
      er[g]    = 1'b1;
      ea       = (g == 1) ? a1 : a0;
      exp_last = g;
      e.due    = cyc + READ_LATENCY;
      e.owner  = er;
      e.instr  = mem_word(ea);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    bus.req_valid = '0; bus.req_addr = '0; bus.mem_ready = 1'b1; inject = 1'b0;
    sb.delete();
    exp_last = NUM_REQ - 1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_read_request, bus.mem_addr, bus.resp_valid, bus.err_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rd=%b addr=%h rvalid=%b err=%b, want all 0",
               bus.req_ready, bus.mem_read_request, bus.mem_addr, bus.resp_valid, bus.err_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_single_read;
    logic [1:0] er; logic [31:0] ea;
    drive(2'b01, 32'h10, 32'h0, 1'b1);
    predict(2'b01, 32'h10, 32'h0, 1'b1, er, ea);
    checks++;
    if (bus.req_ready !== 2'b01 || bus.mem_addr !== 32'h10 || bus.mem_read_request !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got ready=%b addr=%h rd=%b, want ready=01 addr=00000010 rd=1",
               bus.req_ready, bus.mem_addr, bus.mem_read_request);
    end
    idle(3);
    checks++;
    if (bus.err_out !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_done: got err=%b pending=%0d, want err=0 pending=0", bus.err_out, sb.size());
    end
  endtask

  task automatic test_arbitration;
    logic [1:0] er; logic [31:0] ea;
    int n1 = 0;
    int want_n1;
`ifdef ARB_ROUND_ROBIN_EN
    want_n1 = 3;
`else
    want_n1 = 0;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 32'h100, 32'h200, 1'b1);
      predict(2'b11, 32'h100, 32'h200, 1'b1, er, ea);
      n1 += int'(bus.req_ready[1]);
      checks++;
      if (bus.req_ready !== er || bus.mem_addr !== ea) begin
        errors++;
        $display("FAIL arb_grant %0d: got ready=%b addr=%h, want ready=%b addr=%h",
                 i, bus.req_ready, bus.mem_addr, er, ea);
      end
    end
    checks++;
    if (n1 != want_n1) begin
      errors++;
      $display("FAIL arb_share: got %0d grants to requester 1, want %0d", n1, want_n1);
    end
    idle(3);
    checks++;
    if (bus.err_out !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL arb_done: got err=%b pending=%0d, want err=0 pending=0", bus.err_out, sb.size());
    end
  endtask

  task automatic test_mem_not_ready;
    logic [1:0] er; logic [31:0] ea;
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 32'h300, 32'h400, 1'b0);
      predict(2'b11, 32'h300, 32'h400, 1'b0, er, ea);
      checks++;
      if (bus.req_ready !== 2'b00 || bus.mem_read_request !== 1'b0 || bus.mem_addr !== 32'h0) begin
        errors++;
        $display("FAIL blocked %0d: got ready=%b rd=%b addr=%h, want 00 0 00000000",
                 i, bus.req_ready, bus.mem_read_request, bus.mem_addr);
      end
    end
    drive(2'b11, 32'h300, 32'h400, 1'b1);
    predict(2'b11, 32'h300, 32'h400, 1'b1, er, ea);
    checks++;
    if (bus.req_ready !== 2'b01 || bus.mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL unblocked: got ready=%b addr=%h, want ready=01 addr=00000300",
               bus.req_ready, bus.mem_addr);
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    logic [1:0] er; logic [31:0] ea;
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 32'h0, addrs[i], 1'b1);
      predict(2'b10, 32'h0, addrs[i], 1'b1, er, ea);
      checks++;
      if (bus.req_ready !== 2'b10 || bus.mem_addr !== addrs[i]) begin
        errors++;
        $display("FAIL b2b_grant %0d: got ready=%b addr=%h, want ready=10 addr=%h",
                 i, bus.req_ready, bus.mem_addr, addrs[i]);
      end
    end
    idle(3);
    checks++;
    if (bus.err_out !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_done: got err=%b pending=%0d, want err=0 pending=0", bus.err_out, sb.size());
    end
  endtask

  task automatic test_error_inject;
    @(posedge clk_in); #1;
    inject = 1'b1;
    @(posedge clk_in); #1;
    inject = 1'b0;
    checks++;
    if (bus.err_out !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got err=%b, want 1", bus.err_out);
    end
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (bus.err_out !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got err=%b, want 1", bus.err_out);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] er; logic [31:0] ea;
    drive(2'b01, 32'h40, 32'h0, 1'b1);
    predict(2'b01, 32'h40, 32'h0, 1'b1, er, ea);
    @(posedge clk_in); #1;
    bus.req_valid = '0;
    #2;
    rst_in = 1'b1;
    sb.delete();
    exp_last = NUM_REQ - 1;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_read_request, bus.mem_addr, bus.resp_valid, bus.err_out} !== '0) begin
      errors++;
      $display("FAIL reset_async: got ready=%b rd=%b addr=%h rvalid=%b err=%b, want all 0",
               bus.req_ready, bus.mem_read_request, bus.mem_addr, bus.resp_valid, bus.err_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(4);
    checks++;
    if (bus.err_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_err: got err=%b, want 0", bus.err_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.mem_ready = 1'b0;
    inject        = 1'b0;
    test_reset();
    test_single_read();
    test_arbitration();
    test_reset();
    test_mem_not_ready();
    test_back_to_back();
    test_error_inject();
    test_reset();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
